// File: rtl/muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_if
// Bundles the issue, multiplier, divider and result signals of the EX-stage
// multiply/divide controller.
//   Decode side : start, op, src_a, src_b, flush  (to controller)
//                 busy, done, result              (from controller)
//   Multiplier  : a_q, b_q, mul_ce, mul_sign      (from controller)
//                 mul_p                           (to controller)
//   Divider     : a_q, b_q, div_valid, div_sign, div_abort (from controller)
//                 div_ready, div_result           (to controller)
// Modports:
//   master : environment view (decode, multiplier and divider together)
//   slave  : controller view
// ---------------------------------------------------------------------------
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        mul_ce;
  logic        mul_sign;
  logic [63:0] mul_p;
  logic        div_valid;
  logic        div_sign;
  logic        div_abort;
  logic        div_ready;
  logic [63:0] div_result;
  logic        busy;
  logic        done;
  logic [63:0] result;

  modport master (
    output start, op, src_a, src_b, flush, mul_p, div_ready, div_result,
    input  a_q, b_q, mul_ce, mul_sign, div_valid, div_sign, div_abort,
           busy, done, result
  );

  modport slave (
    input  start, op, src_a, src_b, flush, mul_p, div_ready, div_result,
    output a_q, b_q, mul_ce, mul_sign, div_valid, div_sign, div_abort,
           busy, done, result
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Sequencing controller for the EX-stage multiply/divide resources. Accepts
// one MULT/MULTU/DIV/DIVU at a time, latches the operands, drives the
// pipelined multiplier clock enable or the divider start/abort handshake,
// stalls EX while in flight and returns {HI,LO} with a one-cycle done pulse.
// Flushes abort an in-flight operation without producing a result.
//
// Parameters:
//   MULT_LAT : CE-enabled clocks the multiplier needs before P is valid (1..15)
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   bus      : muldiv_ctrl_if.slave (issue, multiplier, divider, result)
//
// Build option:
//   MULDIV_DIV0_BYPASS_EN : when defined, a divide by zero skips the divider
//                           and completes after one cycle with
//                           {dividend, 32'hFFFF_FFFF}.
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int unsigned MULT_LAT = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RES_W   = 64;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MULT_LAT);

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_MULT = 3'd1;
  localparam logic [STATE_W-1:0] S_DIV  = 3'd2;
  localparam logic [STATE_W-1:0] S_DONE = 3'd3;
  localparam logic [STATE_W-1:0] S_DIV0 = 3'd4;

  // State and datapath registers
  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_a_q;
  logic [DATA_W-1:0]  r_b_q;
  logic [RES_W-1:0]   r_result;
  logic               r_sign;
  logic               r_busy;
  logic               r_done;
  logic               r_div_valid;
  logic               r_div_abort;

  // Next-state values
  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]  w_a_nxt;
  logic [DATA_W-1:0]  w_b_nxt;
  logic [RES_W-1:0]   w_result_nxt;
  logic               w_sign_nxt;
  logic               w_busy_nxt;
  logic               w_div_valid_nxt;
  logic               w_div_abort_nxt;
  logic               w_accept;

  // A new operation may only be taken from IDLE or from the DONE cycle
  assign w_accept = bus.start && !bus.flush &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_a_nxt         = r_a_q;
    w_b_nxt         = r_b_q;
    w_result_nxt    = r_result;
    w_sign_nxt      = r_sign;
    w_div_valid_nxt = 1'b0;
    w_div_abort_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
        if (w_accept) begin
          w_a_nxt    = bus.src_a;
          w_b_nxt    = bus.src_b;
          w_sign_nxt = ~bus.op[0];
          w_cnt_nxt  = '0;
          if (!bus.op[1]) begin
            w_state_nxt = S_MULT;
          end else begin
`ifdef MULDIV_DIV0_BYPASS_EN
            if (bus.src_b == '0) begin
              w_state_nxt = S_DIV0;
            end else begin
              w_state_nxt     = S_DIV;
              w_div_valid_nxt = 1'b1;
            end
`else
            w_state_nxt     = S_DIV;
            w_div_valid_nxt = 1'b1;
`endif
          end
        end
      end

      S_MULT: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == LAT_C) begin
          w_result_nxt = bus.mul_p;
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_DIV: begin
        // cnt==0 marks the launch cycle; ready is only trusted afterwards
        if (bus.flush) begin
          w_state_nxt     = S_IDLE;
          w_div_abort_nxt = 1'b1;
        end else if (r_cnt == '0) begin
          w_cnt_nxt = CNT_W'(1);
        end else if (bus.div_ready) begin
          w_result_nxt = bus.div_result;
          w_state_nxt  = S_DONE;
        end
      end

      S_DIV0: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_result_nxt = {r_a_q, 32'hFFFF_FFFF};
          w_state_nxt  = S_DONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_MULT) || (w_state_nxt == S_DIV) ||
                 (w_state_nxt == S_DIV0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a_q       <= '0;
      r_b_q       <= '0;
      r_result    <= '0;
      r_sign      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_valid <= 1'b0;
      r_div_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_a_q       <= w_a_nxt;
      r_b_q       <= w_b_nxt;
      r_result    <= w_result_nxt;
      r_sign      <= w_sign_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= (w_state_nxt == S_DONE);
      r_div_valid <= w_div_valid_nxt;
      r_div_abort <= w_div_abort_nxt;
    end
  end

  // Multiplier enable drops in the same cycle a flush arrives
  assign bus.mul_ce    = (r_state == S_MULT) && (r_cnt < LAT_C) && !bus.flush;

  assign bus.a_q       = r_a_q;
  assign bus.b_q       = r_b_q;
  assign bus.mul_sign  = r_sign;
  assign bus.div_sign  = r_sign;
  assign bus.div_valid = r_div_valid;
  assign bus.div_abort = r_div_abort;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl. Expected outputs are kept as a per-cycle
// timeline derived from the operation timing rules; a compare process checks
// every output against it on each falling edge. Literal checks pin key values.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

  localparam int LAT = 6;
  localparam int NC  = 512;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MULT_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected per-cycle timeline
  bit          e_busy [NC];
  bit          e_done [NC];
  bit          e_ce   [NC];
  bit          e_dv   [NC];
  bit          e_da   [NC];
  bit          e_sign [NC];
  logic [63:0] e_res  [NC];
  logic [31:0] e_a    [NC];
  logic [31:0] e_b    [NC];

  function automatic logic [63:0] mul_model(logic [31:0] a, logic [31:0] b, bit sgn);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

  function automatic logic [63:0] div_model(logic [31:0] a, logic [31:0] b, bit sgn);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Pipelined multiplier stand-in: product emerges after LAT enabled clocks
  logic [63:0] pipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 64'h0;
    end else if (bus.mul_ce) begin
      pipe[0] <= mul_model(bus.a_q, bus.b_q, bus.mul_sign);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.mul_p = pipe[LAT-1];

  // Divider stand-in: result computed at launch, ready timing set by stimulus
  logic [63:0] div_res;
  always @(posedge clk or posedge rst) begin
    if (rst) div_res <= 64'h0;
    else if (bus.div_valid) div_res <= div_model(bus.a_q, bus.b_q, bus.div_sign);
  end
  assign bus.div_result = div_res;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      check("busy",      64'(bus.busy),      64'(e_busy[cyc]));
      check("done",      64'(bus.done),      64'(e_done[cyc]));
      check("mul_ce",    64'(bus.mul_ce),    64'(e_ce[cyc]));
      check("div_valid", 64'(bus.div_valid), 64'(e_dv[cyc]));
      check("div_abort", 64'(bus.div_abort), 64'(e_da[cyc]));
      check("mul_sign",  64'(bus.mul_sign),  64'(e_sign[cyc]));
      check("div_sign",  64'(bus.div_sign),  64'(e_sign[cyc]));
      check("result",    bus.result,         e_res[cyc]);
      check("a_q",       64'(bus.a_q),       64'(e_a[cyc]));
      check("b_q",       64'(bus.b_q),       64'(e_b[cyc]));
    end
  end

  // Timeline builders
  task automatic sched_accept(int s, logic [31:0] a, logic [31:0] b, bit sgn);
    for (int c = s + 1; c < NC; c++) begin
      e_a[c] = a; e_b[c] = b; e_sign[c] = sgn;
    end
  endtask

  task automatic sched_result(int d, logic [63:0] v);
    if (d < NC) e_done[d] = 1'b1;
    for (int c = d; c < NC; c++) e_res[c] = v;
  endtask

  task automatic sched_mult(int s, logic [31:0] a, logic [31:0] b, bit sgn, int f);
    int last;
    sched_accept(s, a, b, sgn);
    last = (f < 0) ? s + LAT + 1 : f;
    for (int c = s + 1; c <= last && c < NC; c++) e_busy[c] = 1'b1;
    for (int c = s + 1; c <= s + LAT && c <= last && c < NC; c++)
      if (c != f) e_ce[c] = 1'b1;
    if (f < 0) sched_result(s + LAT + 2, mul_model(a, b, sgn));
  endtask

  task automatic sched_div(int s, logic [31:0] a, logic [31:0] b, bit sgn, int k, int f);
    int last;
    sched_accept(s, a, b, sgn);
    e_dv[s+1] = 1'b1;
    last = (f < 0) ? k : f;
    for (int c = s + 1; c <= last && c < NC; c++) e_busy[c] = 1'b1;
    if (f < 0) sched_result(k + 1, div_model(a, b, sgn));
    else e_da[f+1] = 1'b1;
  endtask

  task automatic sched_div0(int s, logic [31:0] a);
    sched_accept(s, a, 32'h0, 1'b1);
    e_busy[s+1] = 1'b1;
    sched_result(s + 2, {a, 32'hFFFF_FFFF});
  endtask

  task automatic sched_reset(int r);
    for (int c = r; c < NC; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_ce[c] = 0; e_dv[c] = 0; e_da[c] = 0;
      e_sign[c] = 0; e_res[c] = 64'h0; e_a[c] = 32'h0; e_b[c] = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) tick();
  endtask

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int s, s2;
    for (int c = 0; c < NC; c++) begin
      e_res[c] = 64'h0; e_a[c] = 32'h0; e_b[c] = 32'h0;
    end
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'h0; bus.src_b = 32'h0;
    bus.flush = 1'b0; bus.div_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_result", bus.result, 64'h0);
    tick();

    // MULT -3 * 5
    s = cyc;
    sched_mult(s, 32'hFFFF_FFFD, 32'd5, 1'b1, -1);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mult_sign_lit", 64'(bus.mul_sign), 64'h1);
    wait_cyc(s + 6);
    check("mult_ce6_lit", 64'(bus.mul_ce), 64'h1);
    wait_cyc(s + 7);
    check("mult_busy7_lit", 64'(bus.busy), 64'h1);
    check("mult_ce7_lit", 64'(bus.mul_ce), 64'h0);
    wait_cyc(s + 8);
    check("mult_done_lit", 64'(bus.done), 64'h1);
    check("mult_res_lit", bus.result, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();

    // DIVU 100 / 7, ready at +34, flush during DONE must not kill done
    s = cyc;
    sched_div(s, 32'd100, 32'd7, 1'b0, s + 34, -1);
    issue(2'b11, 32'd100, 32'd7);
    check("divu_valid_lit", 64'(bus.div_valid), 64'h1);
    check("divu_sign_lit", 64'(bus.div_sign), 64'h0);
    tick();
    check("divu_valid2_lit", 64'(bus.div_valid), 64'h0);
    wait_cyc(s + 34);
    bus.div_ready = 1'b1;
    tick();
    bus.div_ready = 1'b0;
    bus.flush = 1'b1;
    check("divu_done_lit", 64'(bus.done), 64'h1);
    check("divu_res_lit", bus.result, 64'h0000_0002_0000_000E);
    tick();
    bus.flush = 1'b0;
    tick();

    // DIV -20 / 3 flushed at +10
    s = cyc;
    sched_div(s, 32'hFFFF_FFEC, 32'd3, 1'b1, 0, s + 10);
    issue(2'b10, 32'hFFFF_FFEC, 32'd3);
    check("div_sign_lit", 64'(bus.div_sign), 64'h1);
    wait_cyc(s + 10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_abort_lit", 64'(bus.div_abort), 64'h1);
    check("flush_busy_lit", 64'(bus.busy), 64'h0);
    check("flush_res_lit", bus.result, 64'h0000_0002_0000_000E);
    tick();
    check("flush_abort2_lit", 64'(bus.div_abort), 64'h0);

    // start with flush in IDLE is dropped
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00;
    bus.src_a = 32'd123; bus.src_b = 32'd456;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("drop_busy_lit", 64'(bus.busy), 64'h0);
    check("drop_aq_lit", 64'(bus.a_q), 64'h0000_0000_FFFF_FFEC);
    tick();

    // Back-to-back MULTU 7*9 then MULT -2*3 issued in the DONE cycle
    s = cyc;
    sched_mult(s, 32'd7, 32'd9, 1'b0, -1);
    issue(2'b01, 32'd7, 32'd9);
    wait_cyc(s + 8);
    check("b2b_done1_lit", 64'(bus.done), 64'h1);
    check("b2b_res1_lit", bus.result, 64'd63);
    s2 = cyc;
    sched_mult(s2, 32'hFFFF_FFFE, 32'd3, 1'b1, -1);
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    check("b2b_busy_lit", 64'(bus.busy), 64'h1);
    check("b2b_done_gap_lit", 64'(bus.done), 64'h0);
    wait_cyc(s2 + 8);
    check("b2b_done2_lit", 64'(bus.done), 64'h1);
    check("b2b_res2_lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();

    // Async reset mid-MULT, then a normal MULT
    s = cyc;
    sched_mult(s, 32'd11, 32'd13, 1'b0, -1);
    issue(2'b01, 32'd11, 32'd13);
    wait_cyc(s + 4);
    sched_reset(s + 4);
    #1 rst = 1'b1;
    #1;
    check("arst_busy_lit", 64'(bus.busy), 64'h0);
    check("arst_ce_lit", 64'(bus.mul_ce), 64'h0);
    check("arst_res_lit", bus.result, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    s = cyc;
    sched_mult(s, 32'd6, 32'd7, 1'b1, -1);
    issue(2'b00, 32'd6, 32'd7);
    wait_cyc(s + 8);
    check("post_rst_res_lit", bus.result, 64'd42);
    tick();

    // MULT flushed at +3: CE drops in the flush cycle
    s = cyc;
    sched_mult(s, 32'd2, 32'd3, 1'b1, s + 3);
    issue(2'b00, 32'd2, 32'd3);
    wait_cyc(s + 3);
    bus.flush = 1'b1;
    #1;
    check("mflush_ce_lit", 64'(bus.mul_ce), 64'h0);
    tick();
    bus.flush = 1'b0;
    check("mflush_busy_lit", 64'(bus.busy), 64'h0);
    tick();

    // DIV 5 / 0
    s = cyc;
`ifdef MULDIV_DIV0_BYPASS_EN
    sched_div0(s, 32'd5);
    issue(2'b10, 32'd5, 32'd0);
    check("div0_valid_lit", 64'(bus.div_valid), 64'h0);
    check("div0_busy_lit", 64'(bus.busy), 64'h1);
    tick();
`else
    sched_div(s, 32'd5, 32'd0, 1'b1, s + 4, -1);
    issue(2'b10, 32'd5, 32'd0);
    check("div0_valid_lit", 64'(bus.div_valid), 64'h1);
    wait_cyc(s + 4);
    bus.div_ready = 1'b1;
    tick();
    bus.div_ready = 1'b0;
`endif
    check("div0_done_lit", 64'(bus.done), 64'h1);
    check("div0_res_lit", bus.result, 64'h0000_0005_FFFF_FFFF);
    repeat (4) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
